alarm_bank: RTL and testbench
=============================

ALARM_BANK -- requirements
Module: alarm_bank

Interface
REQ-001 Parameter NUM_ALARMS, default 4, number of independent alarm channels (2..8); IDX_W = clog2(NUM_ALARMS).
REQ-002 Parameter SNOOZE_MIN, default 5, minutes between snooze press and re-ring (1..15).
REQ-003 Parameter RING_TIMEOUT_MIN, default 10, minutes of unattended ringing before auto-stop (1..15).
REQ-004 clk  input  1  system clock, single clock domain.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 min_tick  input  1  one-cycle pulse, asserted in the cycle cur_h/cur_m take their new minute value.
REQ-007 cur_h  input  5  current hour, 0..23.
REQ-008 cur_m  input  6  current minute, 0..59.
REQ-009 wr_en  input  1  write strobe for an alarm slot.
REQ-010 wr_idx  input  IDX_W  slot written.
REQ-011 wr_h / wr_m / wr_arm  input  5 / 6 / 1  slot hour, minute, armed flag.
REQ-012 ack  input  1  one-cycle pulse (debounced centre button), stops ringing.
REQ-013 snooze  input  1  one-cycle pulse, defers ringing.
REQ-014 ringing  output  1  high while state RING.
REQ-015 ring_idx  output  IDX_W  slot that caused the current RING/SNOOZE.
REQ-016 armed  output  NUM_ALARMS  per-slot armed flags.
REQ-017 snoozing  output  1  high while state SNOOZE.

Function
REQ-018 Slot registers (hour, minute, armed) update on the clk edge with wr_en high; writes with wr_h>23 or wr_m>59 are ignored entirely.
REQ-019 States IDLE, RING, SNOOZE; encoded state register, one transition per clk edge.
REQ-020 IDLE: on min_tick, match = armed slot whose hour/minute equal cur_h/cur_m; any match -> RING next cycle, ring_idx = lowest matching index, minute counter cleared.
REQ-021 RING: ack -> IDLE; snooze -> SNOOZE (counter cleared); each min_tick increments counter; counter reaching RING_TIMEOUT_MIN -> IDLE.
REQ-022 SNOOZE: ack -> IDLE; each min_tick increments counter; counter reaching SNOOZE_MIN -> RING (counter cleared, ring_idx unchanged).
REQ-023 Simultaneous ack and snooze: ack wins.
REQ-024 Simultaneous min_tick and ack/snooze: button transition wins, tick not counted.
REQ-025 Matches occurring while in RING or SNOOZE are dropped, not queued.
REQ-026 Write to slot ring_idx while in RING/SNOOZE does not change state; writing wr_arm=0 to it forces IDLE next cycle.
REQ-027 Slot armed flag persists after ringing (daily repeat); wrap 23:59 -> 00:00 requires no special handling.
REQ-028 Minute counter width 4 bits, never wraps (saturates by transition).
REQ-029 Outputs are registered; ringing rises one cycle after the matching min_tick.

Reset
REQ-030 rst low asynchronously forces state IDLE, counter 0, ring_idx 0, all slot hour/minute 0, armed all 0; ringing=0, snoozing=0.
REQ-031 Reset mid-RING or mid-SNOOZE abandons the alarm; no ring after release until a new match.

Configuration
REQ-032 Macro ALARM_BANK_SNOOZE_EN defined: SNOOZE state and snooze input behave per REQ-021/022.
REQ-033 ALARM_BANK_SNOOZE_EN undefined: SNOOZE state absent, snooze input ignored, snoozing tied 0, SNOOZE_MIN unused.

Verification
REQ-034 Arm slot 1 at 07:30, min_tick with 07:30 -> ringing=1, ring_idx=1 next cycle; ack -> ringing=0 next cycle.
REQ-035 Slots 0 and 2 both 06:00 armed, tick 06:00 -> ring_idx=0.
REQ-036 Ringing, snooze pulse -> snoozing=1; 4 ticks -> still snoozing; 5th tick -> ringing=1 (SNOOZE_MIN=5).
REQ-037 Ringing unattended, 10 min_ticks -> ringing=0 after 10th; matching slot still armed.
REQ-038 Ringing, ack and snooze same cycle -> IDLE; rst low mid-SNOOZE -> all outputs 0 immediately, armed=0.
REQ-039 Write wr_h=24 to slot 3 -> slot 3 unchanged; macro undefined, snooze during ring -> ringing stays 1.

Source files
------------

// File: rtl/alarm_bank.sv
// Multi-slot alarm clock controller: slot registers, match, ring/snooze FSM.
// Optional snooze support is built when ALARM_BANK_SNOOZE_EN is defined.
module alarm_bank #(
    parameter  int NUM_ALARMS       = 4,
    parameter  int SNOOZE_MIN       = 5,
    parameter  int RING_TIMEOUT_MIN = 10,
    localparam int IDX_W            = $clog2(NUM_ALARMS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  min_tick,
    input  logic [4:0]            cur_h,
    input  logic [5:0]            cur_m,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [4:0]            wr_h,
    input  logic [5:0]            wr_m,
    input  logic                  wr_arm,
    input  logic                  ack,
    input  logic                  snooze,
    output logic                  ringing,
    output logic [IDX_W-1:0]      ring_idx,
    output logic [NUM_ALARMS-1:0] armed,
    output logic                  snoozing
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
`ifdef ALARM_BANK_SNOOZE_EN
        S_SNOOZE = 2'd2,
`endif
        S_RING   = 2'd1
    } state_t;

    localparam logic [3:0] RING_LIM = 4'(RING_TIMEOUT_MIN);

    logic [4:0]            slot_h [NUM_ALARMS];
    logic [5:0]            slot_m [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] arm_q;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;

    logic                  idx_ok;
    logic                  wr_ok;
    logic [NUM_ALARMS-1:0] hit;
    logic                  any_hit;
    logic [IDX_W-1:0]      low_idx;
    logic                  drop;
    logic [3:0]            cnt_inc;

    assign idx_ok = {1'b0, wr_idx} < (IDX_W+1)'(NUM_ALARMS);
    assign wr_ok  = wr_en && idx_ok &&
                    (wr_h <= 5'd23) && (wr_m <= 6'd59);

    // Out-of-range times reject the whole write, armed flag included.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                slot_h[i] <= '0;
                slot_m[i] <= '0;
            end
            arm_q <= '0;
        end else if (wr_ok) begin
            slot_h[wr_idx] <= wr_h;
            slot_m[wr_idx] <= wr_m;
            arm_q[wr_idx]  <= wr_arm;
        end
    end

    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            hit[i] = arm_q[i] &&
                     (slot_h[i] == cur_h) &&
                     (slot_m[i] == cur_m);
        end
    end

    // Scan downward so the lowest matching slot is the one kept.
    always_comb begin
        low_idx = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (hit[i]) begin
                low_idx = IDX_W'(i);
            end
        end
    end

    assign any_hit = |hit;
    assign drop    = wr_ok && !wr_arm && (wr_idx == idx_q);
    assign cnt_inc = cnt_q + 4'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        unique case (state_q)
            S_IDLE: begin
                if (min_tick && any_hit) begin
                    state_d = S_RING;
                    cnt_d   = '0;
                    idx_d   = low_idx;
                end
            end
            S_RING: begin
                if (ack || drop) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
`ifdef ALARM_BANK_SNOOZE_EN
                end else if (snooze) begin
                    state_d = S_SNOOZE;
                    cnt_d   = '0;
`endif
                end else if (min_tick) begin
                    if (cnt_inc == RING_LIM) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_inc;
                    end
                end
            end
`ifdef ALARM_BANK_SNOOZE_EN
            S_SNOOZE: begin
                if (ack || drop) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (snooze) begin
                    cnt_d   = cnt_q;
                end else if (min_tick) begin
                    if (cnt_inc == 4'(SNOOZE_MIN)) begin
                        state_d = S_RING;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_inc;
                    end
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    assign ringing  = (state_q == S_RING);
    assign ring_idx = idx_q;
    assign armed    = arm_q;

`ifdef ALARM_BANK_SNOOZE_EN
    assign snoozing = (state_q == S_SNOOZE);
`else
    assign snoozing = 1'b0;

    logic unused_snz;
    assign unused_snz = ^{snooze, 4'(SNOOZE_MIN)};
`endif

endmodule

// File: tb/tb_alarm_bank.sv
// Directed scoreboard bench for alarm_bank (default parameters).
// Snooze-specific steps follow ALARM_BANK_SNOOZE_EN.
module tb_alarm_bank;

    logic       clk = 1'b0;
    logic       rst;
    logic       min_tick;
    logic [4:0] cur_h;
    logic [5:0] cur_m;
    logic       wr_en;
    logic [1:0] wr_idx;
    logic [4:0] wr_h;
    logic [5:0] wr_m;
    logic       wr_arm;
    logic       ack;
    logic       snooze;
    logic       ringing;
    logic [1:0] ring_idx;
    logic [3:0] armed;
    logic       snoozing;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string      tag;
        logic [7:0] exp;
        logic [7:0] mask;
    } exp_t;

    exp_t sb[$];

    alarm_bank dut (
        .clk      (clk),
        .rst      (rst),
        .min_tick (min_tick),
        .cur_h    (cur_h),
        .cur_m    (cur_m),
        .wr_en    (wr_en),
        .wr_idx   (wr_idx),
        .wr_h     (wr_h),
        .wr_m     (wr_m),
        .wr_arm   (wr_arm),
        .ack      (ack),
        .snooze   (snooze),
        .ringing  (ringing),
        .ring_idx (ring_idx),
        .armed    (armed),
        .snoozing (snoozing)
    );

    always #5 clk = ~clk;

    // idx_care=0 when ring_idx carries no meaning (idle)
    task automatic push(input string tag, input logic r,
                        input logic s, input logic [1:0] idx,
                        input logic [3:0] arm, input bit idx_care);
        exp_t e;
        e.tag  = tag;
        e.exp  = {r, s, idx, arm};
        e.mask = {2'b11, idx_care ? 2'b11 : 2'b00, 4'hf};
        sb.push_back(e);
    endtask

    task automatic check();
        exp_t e;
        logic [7:0] obs;
        if (sb.size() == 0) begin
            failures++;
            checks++;
            $error("FAIL sb_empty observed=none expected=entry");
            return;
        end
        e   = sb.pop_front();
        obs = {ringing, snoozing, ring_idx, armed};
        checks++;
        assert ((obs & e.mask) === (e.exp & e.mask))
        else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b mask=%b",
                   e.tag, obs, e.exp, e.mask);
        end
    endtask

    task automatic tick(input int h, input int m);
        @(negedge clk);
        min_tick = 1'b1;
        cur_h    = 5'(h);
        cur_m    = 6'(m);
        @(negedge clk);
        min_tick = 1'b0;
    endtask

    task automatic wr(input int idx, input int h,
                      input int m, input logic arm);
        @(negedge clk);
        wr_en  = 1'b1;
        wr_idx = 2'(idx);
        wr_h   = 5'(h);
        wr_m   = 6'(m);
        wr_arm = arm;
        @(negedge clk);
        wr_en  = 1'b0;
    endtask

    task automatic btn(input logic a, input logic s);
        @(negedge clk);
        ack    = a;
        snooze = s;
        @(negedge clk);
        ack    = 1'b0;
        snooze = 1'b0;
    endtask

    initial begin
        rst      = 1'b0;
        min_tick = 1'b0;
        cur_h    = '0;
        cur_m    = '0;
        wr_en    = 1'b0;
        wr_idx   = '0;
        wr_h     = '0;
        wr_m     = '0;
        wr_arm   = 1'b0;
        ack      = 1'b0;
        snooze   = 1'b0;

        repeat (3) @(negedge clk);
        push("reset", 0, 0, 2'd0, 4'b0000, 1);
        check();
        rst = 1'b1;

        push("arm_s1", 0, 0, 2'd0, 4'b0010, 0);
        wr(1, 7, 30, 1'b1);
        check();

        push("ring_0730", 1, 0, 2'd1, 4'b0010, 1);
        tick(7, 30);
        check();

        push("ack_stop", 0, 0, 2'd0, 4'b0010, 0);
        btn(1'b1, 1'b0);
        check();

        wr(0, 6, 0, 1'b1);
        push("arm_s0_s2", 0, 0, 2'd0, 4'b0111, 0);
        wr(2, 6, 0, 1'b1);
        check();

        push("lowest_idx", 1, 0, 2'd0, 4'b0111, 1);
        tick(6, 0);
        check();

        for (int k = 0; k < 9; k++) tick(12, k);
        push("ring_9_ticks", 1, 0, 2'd0, 4'b0111, 1);
        check();
        push("timeout_10", 0, 0, 2'd0, 4'b0111, 0);
        tick(12, 9);
        check();

        tick(7, 30);
        push("ack_and_snooze", 0, 0, 2'd0, 4'b0111, 0);
        btn(1'b1, 1'b1);
        check();

        tick(6, 0);
        push("match_dropped", 1, 0, 2'd0, 4'b0111, 1);
        tick(7, 30);
        check();
        btn(1'b1, 1'b0);
        push("not_queued", 0, 0, 2'd0, 4'b0111, 0);
        tick(12, 20);
        check();

        push("bad_hour", 0, 0, 2'd0, 4'b0111, 0);
        wr(3, 24, 0, 1'b1);
        check();
        push("bad_minute", 0, 0, 2'd0, 4'b0111, 0);
        wr(0, 6, 60, 1'b0);
        check();
        push("s3_unarmed", 0, 0, 2'd0, 4'b0111, 0);
        tick(0, 0);
        check();

        tick(7, 30);
        push("wr_other_slot", 1, 0, 2'd1, 4'b1111, 1);
        wr(3, 0, 0, 1'b1);
        check();
        push("disarm_ringing", 0, 0, 2'd0, 4'b1101, 0);
        wr(1, 7, 30, 1'b0);
        check();

        push("wrap_2359", 0, 0, 2'd0, 4'b1101, 0);
        tick(23, 59);
        check();
        push("wrap_0000", 1, 0, 2'd3, 4'b1101, 1);
        tick(0, 0);
        check();
        btn(1'b1, 1'b0);

        tick(6, 0);
`ifdef ALARM_BANK_SNOOZE_EN
        push("snooze_enter", 0, 1, 2'd0, 4'b1101, 1);
        btn(1'b0, 1'b1);
        check();
        for (int k = 0; k < 4; k++) tick(13, k);
        push("snooze_4", 0, 1, 2'd0, 4'b1101, 1);
        check();
        push("snooze_5", 1, 0, 2'd0, 4'b1101, 1);
        tick(13, 4);
        check();
        btn(1'b0, 1'b1);
`else
        push("snooze_ignored", 1, 0, 2'd0, 4'b1101, 1);
        btn(1'b0, 1'b1);
        check();
`endif

        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        push("async_reset", 0, 0, 2'd0, 4'b0000, 1);
        check();
        @(negedge clk);
        rst = 1'b1;
        push("no_ring_after", 0, 0, 2'd0, 4'b0000, 0);
        tick(6, 0);
        check();

        if (sb.size() != 0) begin
            failures++;
            $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
